// File: rtl/gf_asm_ctrl.sv
// Sequential GF(2^WIDTH) multiplier controller: MSB-first shift/reduce/XOR
// datapath, one step per cycle, with a start/ready/busy/done handshake.
module gf_asm_ctrl #(
    parameter int unsigned     SIZE = 8,
    parameter logic [SIZE/2:0] POLY = 5'b10011
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [SIZE-1:0]           in,
    output logic                      ready,
    output logic                      busy,
    output logic                      done,
    output logic [SIZE/2-1:0]         out,
    output logic [$clog2(SIZE/2):0]   cnt
);

    localparam int unsigned WIDTH = SIZE / 2;
    localparam int unsigned IW    = $clog2(WIDTH);
    localparam int unsigned CW    = IW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   a_r, a_n;
    logic [WIDTH-1:0]   b_r, b_n;
    logic [WIDTH-1:0]   acc, acc_n;
    logic [CW-1:0]      cnt_n;
    logic [WIDTH-1:0]   out_n;
    logic               done_n;
    logic               ready_n;
    logic               busy_n;
    logic [IW-1:0]      idx;
    logic [WIDTH:0]     t;
    logic [WIDTH-1:0]   step;

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
            out   <= '0;
            done  <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            a_r   <= a_n;
            b_r   <= b_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            out   <= out_n;
            done  <= done_n;
            ready <= ready_n;
            busy  <= busy_n;
        end
    end

    // Next-state logic and one multiply step (shift, reduce, conditional add).
    always_comb begin
        state_n = state;
        a_n     = a_r;
        b_n     = b_r;
        acc_n   = acc;
        cnt_n   = cnt;
        out_n   = out;
        done_n  = 1'b0;

        idx  = IW'(cnt - CW'(1));
        t    = {acc, 1'b0};
        if (t[WIDTH]) begin
            t = t ^ POLY;
        end
        step = t[WIDTH-1:0] ^ (b_r[idx] ? a_r : '0);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_n     = in[SIZE-1:WIDTH];
                    b_n     = in[WIDTH-1:0];
                    acc_n   = '0;
                    cnt_n   = CW'(WIDTH);
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                acc_n = step;
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    out_n   = step;
                    done_n  = 1'b1;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase

        ready_n = (state_n != RUN);
        busy_n  = (state_n == RUN);
    end

endmodule

// File: tb/tb_gf_asm_ctrl.sv
// Scoreboard bench for gf_asm_ctrl: driver pushes expected products, monitor
// pops and compares on every done pulse.
module tb_gf_asm_ctrl;

    localparam int unsigned SIZE = 8;
    localparam int unsigned W    = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [SIZE-1:0] din;
    logic           ready;
    logic           busy;
    logic           done;
    logic [W-1:0]   dout;
    logic [2:0]     cnt;

    typedef struct {
        logic [W-1:0] val;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    logic [W-1:0] last_out = '0;

    gf_asm_ctrl #(.SIZE(SIZE), .POLY(5'b10011)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (din),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .out   (dout),
        .cnt   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    // Reference: carry-less product, then polynomial long-division reduction.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-2:0] p;
        logic [2*W-2:0] poly;
        p    = '0;
        poly = (2*W-1)'(5'b10011);
        for (int i = 0; i < W; i++)
            if (b[i]) p = p ^ ((2*W-1)'(a) << i);
        for (int i = 2*W-2; i >= W; i--)
            if (p[i]) p = p ^ (poly << (i - W));
        return p[W-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wait for ready, present operands, record expected result at acceptance.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e, input bit hold, output int acc_cyc);
        int t = 0;
        @(negedge clk);
        while (!ready && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            check("ready_timeout", 32'(ready), 32'd1);
            acc_cyc = -1;
            return;
        end
        din   = {a, b};
        start = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        sb.push_back('{e, cyc + int'(W)});
        if (!hold) start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: compare each done pulse against the scoreboard; out must hold otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                last_out = '0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", 32'(dout), 32'(e.val));
                    check("latency", 32'(cyc), 32'(e.due));
                    last_out = e.val;
                end
            end else begin
                check("out_hold", 32'(dout), 32'(last_out));
            end
        end
    end

    initial begin
        int c0, c1, t;
        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_out", 32'(dout), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);

        // Directed results: identity, reduction path, all-ones, zero operands.
        issue(4'b0101, 4'b0001, 4'b0101, 1'b0, c0);
        drain();
        repeat (10) begin
            @(negedge clk);
            check("idle_done", 32'(done), 32'd0);
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_out", 32'(dout), 32'h5);
        end
        issue(4'b1000, 4'b0010, 4'b0011, 1'b0, c0);
        issue(4'b1111, 4'b1111, 4'b1010, 1'b0, c0);
        issue(4'b0000, 4'b1011, 4'b0000, 1'b0, c0);
        issue(4'b0110, 4'b0000, 4'b0000, 1'b0, c0);
        drain();

        // Start and operands disturbed during RUN must be ignored.
        issue(4'b1001, 4'b0111, gf_mul(4'b1001, 4'b0111), 1'b0, c0);
        @(negedge clk);
        start = 1'b1;
        din   = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        drain();

        // start held high: back-to-back results every WIDTH+1 cycles.
        issue(4'h3, 4'hC, gf_mul(4'h3, 4'hC), 1'b1, c0);
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(0, 15));
            issue(a, b, gf_mul(a, b), 1'b1, c1);
            check("b2b_spacing", 32'(c1 - c0), 32'(W + 1));
            c0 = c1;
        end
        start = 1'b0;
        drain();

        // Reset mid-RUN abandons the result asynchronously; no done afterwards.
        issue(4'h7, 4'hB, gf_mul(4'h7, 4'hB), 1'b0, c0);
        t = 0;
        while (!(busy && cnt == 3'd2) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("cnt2_reached", 32'(cnt), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("arst_out", 32'(dout), 32'd0);
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_done", 32'(done), 32'd0);
        end
        issue(4'h3, 4'h7, gf_mul(4'h3, 4'h7), 1'b0, c0);
        drain();

        // Exhaustive sweep with random idle gaps.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(W'(a), W'(b), gf_mul(W'(a), W'(b)), 1'b0, c0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
